router_port_arbiter: RTL and testbench
======================================

ROUTER_PORT_ARBITER -- requirements
Module: router_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 5, number of requesters sharing one router output port (LEFT=0, RIGHT=1, UP=2, DOWN=3, LOCAL=4).
REQ-002 Parameter FLIT_W, default 64, flit width: [63:48] dest x, [47:32] dest y, [31:0] payload.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  system clock, all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port req_valid  input  NUM_REQ  per-requester flit valid.
REQ-007 Port req_flit  input  NUM_REQ*FLIT_W  per-requester flit, requester i at bits [i*FLIT_W +: FLIT_W].
REQ-008 Port req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-009 Port out_valid  output  1  output register holds a flit.
REQ-010 Port out_flit  output  FLIT_W  registered granted flit.
REQ-011 Port out_ready  input  1  downstream router/link accepts out_flit.
REQ-012 Port grant_id  output  3  index of the requester whose flit sits in the output register.
REQ-013 Port stat_count  output  16  accepted-flit counter, present only with ARB_STATS_EN.

Function
REQ-014 Output register SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 load SHALL be (~out_valid | out_ready), evaluated combinationally each cycle.
REQ-016 When load=1 and any req_valid=1, sel SHALL be the first set req_valid index searching ptr, ptr+1, ... modulo NUM_REQ.
REQ-017 req_ready[sel] SHALL be 1 combinationally in that cycle; all other req_ready bits 0.
REQ-018 When load=0 or no req_valid is set, all req_ready SHALL be 0.
REQ-019 On a handshake, next edge: out_valid<=1, out_flit<=req_flit[sel], grant_id<=sel, ptr<=(sel==NUM_REQ-1)?0:sel+1; latency 1 cycle.
REQ-020 When load=1 and no request is set: out_valid<=0; out_flit, grant_id and ptr hold.
REQ-021 While out_valid=1 and out_ready=0, out_flit and grant_id SHALL remain stable and no new grant SHALL be issued.
REQ-022 With out_ready held 1 and requests present, throughput SHALL be one flit per cycle (drain and refill in the same cycle).
REQ-023 A requester dropping req_valid before grant SHALL be skipped without side effects; ptr changes only on a grant.
REQ-024 No requester SHALL wait more than NUM_REQ-1 grants while continuously valid.

Reset
REQ-025 While rst=1 at a clock edge: out_valid=0, out_flit=0, grant_id=0, ptr=0, stat_count=0.
REQ-026 While rst=1, req_ready SHALL be all 0; a flit held in the output register at reset SHALL be discarded.

Configuration
REQ-027 Macro ARB_STATS_EN: when defined, stat_count exists and increments by 1 on each cycle with out_valid & out_ready, saturating at 16'hFFFF.
REQ-028 When ARB_STATS_EN is undefined, stat_count and its counter SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-029 Shared package noc_pkg SHALL hold FLIT_W, dest-x/dest-y/payload field positions, and the port index constants LEFT/RIGHT/UP/DOWN/LOCAL.
REQ-030 One combinational sub-module rr_pick SHALL compute sel and an any-valid flag from req_valid and ptr; registers stay in router_port_arbiter.

Verification
REQ-031 Reset, then req_valid=5'b00000 for 10 cycles -> out_valid=0, req_ready=0, grant_id=0 throughout.
REQ-032 req_valid=5'b10001 held, out_ready=1, ptr=0 -> grants alternate 0,4,0,4; out_flit matches requester flit one cycle after each req_ready.
REQ-033 All 5 valid, out_ready=1 -> grant_id sequence 0,1,2,3,4,0 on consecutive cycles, one flit/cycle.
REQ-034 Requester 2 sends 64'h0003000300000055, out_ready=0 for 4 cycles -> out_flit holds 64'h0003000300000055, req_ready all 0 until out_ready=1.
REQ-035 rst asserted while out_valid=1 and req_valid=5'b11111 -> next cycle out_valid=0, ptr=0; after release first grant is requester 0.
REQ-036 With ARB_STATS_EN, 70000 back-to-back handshakes -> stat_count=16'hFFFF, no wrap.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, field positions, router port indices,
// and the output-register state type used by the port arbiter.
package noc_pkg;

  localparam int unsigned FLIT_W      = 64;
  localparam int unsigned DEST_X_MSB  = 63;
  localparam int unsigned DEST_X_LSB  = 48;
  localparam int unsigned DEST_Y_MSB  = 47;
  localparam int unsigned DEST_Y_LSB  = 32;
  localparam int unsigned PAYLOAD_MSB = 31;
  localparam int unsigned PAYLOAD_LSB = 0;

  // Width of a requester index (grant_id, round-robin pointer)
  localparam int unsigned IDX_W = 3;

  localparam logic [IDX_W-1:0] LEFT  = 3'd0;
  localparam logic [IDX_W-1:0] RIGHT = 3'd1;
  localparam logic [IDX_W-1:0] UP    = 3'd2;
  localparam logic [IDX_W-1:0] DOWN  = 3'd3;
  localparam logic [IDX_W-1:0] LOCAL = 3'd4;

  typedef enum logic {
    OREG_EMPTY,
    OREG_FULL
  } oreg_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first valid requester at or after ptr, modulo NUM_REQ.
module rr_pick
  import noc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 5
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any_valid
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] idx;

  // Walk ptr, ptr+1, ... wrapping at NUM_REQ; the first valid requester wins
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (IDX_W+1)'(i);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_valid && req_valid[idx[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        sel       = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/router_port_arbiter.sv
// Round-robin arbiter for one router output port with a single-entry output
// register. Optional accepted-flit counter enabled by macro ARB_STATS_EN.
module router_port_arbiter #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned FLIT_W  = noc_pkg::FLIT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [FLIT_W-1:0]         out_flit,
  input  logic                      out_ready,
`ifdef ARB_STATS_EN
  output logic [15:0]               stat_count,
`endif
  output logic [2:0]                grant_id
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

  noc_pkg::oreg_state_e state_q, state_d;

  logic [2:0]        ptr_q;
  logic [2:0]        sel;
  logic              any_valid;
  logic              load;
  logic              grant;
  logic [FLIT_W-1:0] sel_flit;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .sel       (sel),
    .any_valid (any_valid)
  );

  assign out_valid = (state_q == noc_pkg::OREG_FULL);

  // Load/grant decode, one-hot ready and output-register next state
  always_comb begin
    load      = ~out_valid | out_ready;
    grant     = load & any_valid & ~rst;
    req_ready = '0;
    state_d   = state_q;
    if (grant) req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
    if (load) state_d = any_valid ? noc_pkg::OREG_FULL : noc_pkg::OREG_EMPTY;
  end

  // Mux the selected requester's flit
  always_comb begin
    sel_flit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(sel) == i) sel_flit = req_flit[i*FLIT_W +: FLIT_W];
    end
  end

  // Output-register state
  always_ff @(posedge clk) begin
    if (rst) state_q <= noc_pkg::OREG_EMPTY;
    else     state_q <= state_d;
  end

  // Flit, grant index and round-robin pointer update only on a handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flit <= '0;
      grant_id <= '0;
      ptr_q    <= '0;
    end else if (grant) begin
      out_flit <= sel_flit;
      grant_id <= sel;
      ptr_q    <= (sel == LAST_IDX) ? 3'd0 : sel + 3'd1;
    end
  end

`ifdef ARB_STATS_EN
  // Saturating count of flits accepted downstream
  always_ff @(posedge clk) begin
    if (rst)                                        stat_count <= '0;
    else if (out_valid && out_ready && stat_count != '1) stat_count <= stat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_router_port_arbiter.sv
// Randomized self-checking bench for router_port_arbiter with a behavioural
// model (round-robin pointer, one-entry output slot, saturating counter).
module tb_router_port_arbiter;

  localparam int N = 5;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_flit;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_flit;
  logic             out_ready;
  logic [2:0]       grant_id;
`ifdef ARB_STATS_EN
  logic [15:0]      stat_count;
`endif

  router_port_arbiter #(
    .NUM_REQ (N),
    .FLIT_W  (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_flit   (req_flit),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_flit   (out_flit),
    .out_ready  (out_ready),
`ifdef ARB_STATS_EN
    .stat_count (stat_count),
`endif
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  bit          m_valid = 0;
  logic [63:0] m_flit  = '0;
  int          m_gid   = 0;
  int          m_ptr   = 0;
  int          m_cnt   = 0;

  logic [63:0] flits [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // First valid requester at or after the model pointer, -1 if none
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic rand_flits();
    for (int i = 0; i < N; i++) flits[i] = {$urandom, $urandom};
  endtask

  // One clock: check combinational and registered outputs, then advance model
  task automatic step();
    int s;
    bit ld;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) req_flit[i*W +: W] = flits[i];
    @(negedge clk);
    s  = pick();
    ld = !m_valid || out_ready;
    exp_rdy = (!rst && ld && s >= 0) ? (5'b00001 << s) : 5'b00000;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_flit",  out_flit, m_flit);
    check("grant_id",  64'(grant_id), 64'(m_gid));
`ifdef ARB_STATS_EN
    check("stat_count", 64'(stat_count), 64'(m_cnt));
`endif
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_flit = '0; m_gid = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_valid && out_ready && m_cnt < 65535) m_cnt++;
      if (ld) begin
        if (s >= 0) begin
          m_valid = 1;
          m_flit  = flits[s];
          m_gid   = s;
          m_ptr   = (s + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    req_flit  = '0;
    for (int i = 0; i < N; i++) flits[i] = '0;

    repeat (2) step();
    rst = 1'b0;

    // Idle: nothing granted, grant_id stays 0
    repeat (10) begin rand_flits(); step(); end

    // Two requesters alternate
    req_valid = 5'b10001;
    repeat (8) begin rand_flits(); step(); end

    // All requesters: strict rotation, one flit per cycle
    req_valid = 5'b11111;
    repeat (12) begin rand_flits(); step(); end

    // Downstream stall holds the flit and blocks grants
    req_valid = 5'b00000;
    repeat (2) step();
    req_valid = 5'b00100;
    flits[2]  = 64'h0003000300000055;
    step();
    req_valid = 5'b11111;
    out_ready = 1'b0;
    repeat (4) begin rand_flits(); flits[2] = 64'h0003000300000055; step(); end
    check("stall_hold_flit", out_flit, 64'h0003000300000055);
    out_ready = 1'b1;
    repeat (3) begin rand_flits(); step(); end

    // Reset while full discards the flit and restarts at requester 0
    out_ready = 1'b0;
    repeat (2) begin rand_flits(); step(); end
    rst = 1'b1;
    step();
    check("rst_clears_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_first_grant", 64'(grant_id), 64'd0);
    repeat (3) begin rand_flits(); step(); end

    // Random traffic with stalls, dropping requesters and occasional reset
    repeat (600) begin
      req_valid = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      rand_flits();
      step();
    end
    rst = 1'b0;

`ifdef ARB_STATS_EN
    // Counter saturation under continuous back-to-back traffic
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 5'b11111;
    out_ready = 1'b1;
    repeat (70000) step();
    check("stat_saturated", 64'(stat_count), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
